// File: rtl/bc_pkg.sv
// Shared types and constants for the basic-computer timing unit.
// Holds the default SC width, NUM_T derivation and the S state type.
package bc_pkg;

   localparam int DEF_SC_WIDTH = 4;

   function automatic int num_t(input int w);
      return 2 ** w;
   endfunction

   typedef enum logic {
      HALTED = 1'b0,
      RUN    = 1'b1
   } state_t;

endpackage

// File: rtl/bc_seq_decoder.sv
// One-hot W-to-2**W decoder with enable (also used for opcodes).
// Ports: sel (W bits), en, y (N bits, all-zero when en=0).
module bc_seq_decoder
   import bc_pkg::*;
#(
   parameter int W = DEF_SC_WIDTH,
   parameter int N = num_t(W)
) (
   input  logic [W-1:0] sel,
   input  logic         en,
   output logic [N-1:0] y
);

   always_comb begin
      y = '0;
      if (en) y[sel] = 1'b1;
   end

endmodule

// File: rtl/bc_timing_unit.sv
// Timing sequencer: start/stop flip-flop S, counter SC, T0..T(N-1).
// Ports: clk, rst, start, hlt, sc_clr -> sc, t, running.
// Optional BC_SINGLE_STEP_EN adds step_mode/step to gate SC moves.
module bc_timing_unit
   import bc_pkg::*;
#(
   parameter int SC_WIDTH = DEF_SC_WIDTH,
   parameter int NUM_T    = num_t(SC_WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                hlt,
   input  logic                sc_clr,
`ifdef BC_SINGLE_STEP_EN
   input  logic                step_mode,
   input  logic                step,
`endif
   output logic [SC_WIDTH-1:0] sc,
   output logic [NUM_T-1:0]    t,
   output logic                running
);

   state_t              state_q, state_d;
   logic [SC_WIDTH-1:0] sc_q, sc_d;
   logic                adv;

`ifdef BC_SINGLE_STEP_EN
   assign adv = !step_mode || step;
`else
   assign adv = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HALTED;
         sc_q    <= '0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
      end
   end

   // hlt beats sc_clr beats increment; wrap at 2**SC_WIDTH is normal
   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      unique case (state_q)
         HALTED: begin
            sc_d = '0;
            if (start) state_d = RUN;
         end
         RUN: begin
            priority case (1'b1)
               hlt: begin
                  state_d = HALTED;
                  sc_d    = '0;
               end
               (adv && sc_clr): sc_d = '0;
               adv:             sc_d = sc_q + SC_WIDTH'(1);
               default:         sc_d = sc_q;
            endcase
         end
         default: begin
            state_d = HALTED;
            sc_d    = '0;
         end
      endcase
   end

   assign sc      = sc_q;
   assign running = (state_q == RUN);

   bc_seq_decoder #(
      .W (SC_WIDTH),
      .N (NUM_T)
   ) u_dec (
      .sel (sc_q),
      .en  (running),
      .y   (t)
   );

endmodule

// File: tb/tb_bc_timing_unit.sv
// Self-checking bench for bc_timing_unit: vector table, corner
// sequences and random stimulus against a behavioural model.
module tb_bc_timing_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, hlt, sc_clr;
`ifdef BC_SINGLE_STEP_EN
   logic        step_mode, step;
`endif
   logic [3:0]  sc;
   logic [15:0] t;
   logic        running;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model: S flag plus integer count
   bit m_run;
   int m_sc;

   typedef struct {
      logic        s, h, c;
      int          esc;
      logic        erun;
      logic [15:0] et;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   bc_timing_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hlt       (hlt),
      .sc_clr    (sc_clr),
`ifdef BC_SINGLE_STEP_EN
      .step_mode (step_mode),
      .step      (step),
`endif
      .sc        (sc),
      .t         (t),
      .running   (running)
   );

   function automatic void add(input logic s, input logic h,
                               input logic c, input int esc,
                               input logic erun,
                               input logic [15:0] et);
      vec_t v;
      v.s = s; v.h = h; v.c = c;
      v.esc = esc; v.erun = erun; v.et = et;
      tbl.push_back(v);
   endfunction

   function automatic logic [15:0] onehot(input int i);
      logic [15:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic check(input string nm, input int esc,
                        input logic erun, input logic [15:0] et);
      n_tests++;
      if (int'(sc) != esc || running !== erun || t !== et) begin
         n_fail++;
         $display("FAIL %s: got sc=%0d run=%0b t=%h, want sc=%0d run=%0b t=%h",
                  nm, sc, running, t, esc, erun, et);
      end
   endtask

   task automatic check_model(input string nm);
      logic [15:0] et;
      et = m_run ? onehot(m_sc) : 16'h0000;
      check(nm, m_sc, m_run, et);
   endtask

   task automatic mdl_edge();
      bit adv;
      adv = 1'b1;
`ifdef BC_SINGLE_STEP_EN
      adv = !step_mode || step;
`endif
      if (!m_run) begin
         m_sc = 0;
         if (start) m_run = 1'b1;
      end else if (hlt) begin
         m_run = 1'b0;
         m_sc  = 0;
      end else if (adv) begin
         m_sc = sc_clr ? 0 : (m_sc + 1) % 16;
      end
   endtask

   task automatic drive(input logic s, input logic h, input logic c);
      start  = s;
      hlt    = h;
      sc_clr = c;
      @(posedge clk);
      mdl_edge();
      #1;
      start  = 1'b0;
      hlt    = 1'b0;
      sc_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0; hlt = 1'b0; sc_clr = 1'b0;
`ifdef BC_SINGLE_STEP_EN
      step_mode = 1'b0; step = 1'b0;
`endif
      m_run = 1'b0; m_sc = 0;

      // free run with wrap
      add(1, 0, 0, 0, 1, 16'h0001);
      for (int i = 1; i < 16; i++) add(0, 0, 0, i, 1, onehot(i));
      add(0, 0, 0, 0, 1, 16'h0001);
      // instruction end at sc=4
      for (int i = 1; i < 5; i++) add(0, 0, 0, i, 1, onehot(i));
      add(0, 0, 1, 0, 1, 16'h0001);
      add(0, 0, 0, 1, 1, 16'h0002);
      // hlt + sc_clr + start at sc=3
      add(0, 0, 0, 2, 1, 16'h0004);
      add(0, 0, 0, 3, 1, 16'h0008);
      add(1, 1, 1, 0, 0, 16'h0000);
      // halted robustness
      add(0, 0, 1, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 0, 16'h0000);
      add(0, 0, 0, 0, 0, 16'h0000);
      add(1, 1, 0, 0, 1, 16'h0001);
      add(0, 0, 0, 1, 1, 16'h0002);
      add(0, 1, 0, 0, 0, 16'h0000);

      #1;
      check("reset_state", 0, 1'b0, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].s, tbl[i].h, tbl[i].c);
         check($sformatf("vec%0d", i),
               tbl[i].esc, tbl[i].erun, tbl[i].et);
      end

      // async reset mid-count at sc=7
      drive(1, 0, 0);
      for (int i = 0; i < 7; i++) drive(0, 0, 0);
      check("pre_reset_sc7", 7, 1'b1, 16'h0080);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 0, 1'b0, 16'h0000);
      m_run = 1'b0; m_sc = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0);
         check($sformatf("post_reset_idle%0d", i), 0, 1'b0, 16'h0000);
      end

      // random stimulus vs model
      for (int i = 0; i < 400; i++) begin
`ifdef BC_SINGLE_STEP_EN
         step_mode = ($urandom_range(3) == 0);
         step      = $urandom_range(1);
`endif
         drive(($urandom_range(3) == 0),
               ($urandom_range(19) == 0),
               ($urandom_range(5) == 0));
         check_model($sformatf("rand%0d", i));
      end

`ifdef BC_SINGLE_STEP_EN
      step_mode = 1'b0; step = 1'b0;
      drive(0, 1, 0);
      drive(0, 0, 0);
      check("ss_halted", 0, 1'b0, 16'h0000);
      step_mode = 1'b1;
      drive(1, 0, 0);
      check("ss_start", 0, 1'b1, 16'h0001);
      step = 1'b1;
      drive(0, 0, 0);
      drive(0, 0, 0);
      check("ss_at2", 2, 1'b1, 16'h0004);
      step = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0);
         check($sformatf("ss_hold%0d", i), 2, 1'b1, 16'h0004);
      end
      step = 1'b1;
      drive(0, 0, 0);
      check("ss_pulse", 3, 1'b1, 16'h0008);
      step = 1'b0;
      drive(0, 0, 1);
      check("ss_clr_gated", 3, 1'b1, 16'h0008);
      drive(0, 1, 0);
      check("ss_hlt", 0, 1'b0, 16'h0000);
      step_mode = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
